// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for up to four requesters with registered one-hot grants.
// Optional hold-time limit and timeout pulse enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter4 #(
    parameter int NREQ     = 4,
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_id,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state_q;
    logic [1:0]      ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic [1:0]      gnt_id_q;
    logic            busy_q;

    logic            win_vld;
    logic [1:0]      win_id;
    logic [1:0]      ptr_d;

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q;
`endif

    // Scan downward so the requester closest to ptr is written last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (req[idx]) begin
                win_vld = 1'b1;
                win_id  = 2'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (win_vld) begin
            ptr_d = (win_id == 2'(NREQ - 1)) ? 2'd0 : win_id + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= '0;
            gnt_id_q  <= 2'd0;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        gnt_q    <= NREQ'(1) << win_id;
                        gnt_id_q <= win_id;
                        busy_q   <= 1'b1;
                        ptr_q    <= ptr_d;
`ifdef ARB_TIMEOUT_EN
                        hold_q   <= '0;
`endif
                        state_q  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // A release in the limit cycle wins over the timeout.
                    if (!req[gnt_id_q]) begin
                        gnt_q    <= '0;
                        gnt_id_q <= 2'd0;
                        busy_q   <= 1'b0;
                        state_q  <= S_GAP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                        gnt_q     <= '0;
                        gnt_id_q  <= 2'd0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_GAP;
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

`ifdef ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_HOLD > HOLD_W);
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4.
// Hold-limit expectations follow whether ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter4;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    rr_arbiter4 #(
        .NREQ(4),
        .HOLD_W(4),
        .MAX_HOLD(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .busy(busy),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [1:0] id_of(input logic [3:0] g);
        id_of = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) id_of = 2'(i);
        end
    endfunction

    function automatic logic [7:0] exp_of(input logic [3:0] g, input logic t);
        exp_of = {g, id_of(g), |g, t};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        req   = 4'b0000;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] ob;
        reset = 1'b0;
        req   = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            step();
            ob = {gnt, gnt_id, busy, timeout};
            checks++;
            if (ob !== 8'h00)
                $display("FAIL reset_hold c%0d: got %b want %b", c, ob, 8'h00);
            if (ob !== 8'h00) errors++;
        end
        reset = 1'b1;
        step();
        ob = {gnt, gnt_id, busy, timeout};
        checks++;
        if (ob !== exp_of(4'b0001, 1'b0)) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want %b",
                     ob, exp_of(4'b0001, 1'b0));
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_voluntary_release();
        logic [3:0] eg [6];
        logic [7:0] ob;
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0100};
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            step();
            ob = {gnt, gnt_id, busy, timeout};
            checks++;
            if (ob !== exp_of(eg[c], 1'b0)) begin
                errors++;
                $display("FAIL release c%0d: got %b want %b",
                         c, ob, exp_of(eg[c], 1'b0));
            end
            if (c == 2) req = 4'b0100;
        end
    endtask

    // Continues from requester 2 holding the grant (ptr = 3).
    task automatic test_pointer_fairness();
        logic [3:0] rq [6];
        logic [3:0] eg [6];
        logic [7:0] ob;
        rq = '{4'b0000, 4'b0101, 4'b0101, 4'b0100, 4'b0101, 4'b0101};
        eg = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100};
        for (int c = 0; c < 6; c++) begin
            req = rq[c];
            step();
            ob = {gnt, gnt_id, busy, timeout};
            checks++;
            if (ob !== exp_of(eg[c], 1'b0)) begin
                errors++;
                $display("FAIL fairness c%0d: got %b want %b",
                         c, ob, exp_of(eg[c], 1'b0));
            end
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_ignore_others();
        logic [3:0] rq [7];
        logic [3:0] eg [7];
        logic [7:0] ob;
        rq = '{4'b1010, 4'b1011, 4'b0010, 4'b1110,
               4'b0000, 4'b1111, 4'b1111};
        eg = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
               4'b0000, 4'b0000, 4'b0100};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req = rq[c];
            step();
            ob = {gnt, gnt_id, busy, timeout};
            checks++;
            if (ob !== exp_of(eg[c], 1'b0)) begin
                errors++;
                $display("FAIL ignore c%0d: got %b want %b",
                         c, ob, exp_of(eg[c], 1'b0));
            end
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_reset_mid_grant();
        logic       rs [5];
        logic [3:0] rq [5];
        logic [3:0] eg [5];
        logic [7:0] ob;
        rs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        rq = '{4'b0100, 4'b0100, 4'b0100, 4'b1100, 4'b1100};
        eg = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            reset = rs[c];
            req   = rq[c];
            step();
            ob = {gnt, gnt_id, busy, timeout};
            checks++;
            if (ob !== exp_of(eg[c], 1'b0)) begin
                errors++;
                $display("FAIL mid_reset c%0d: got %b want %b",
                         c, ob, exp_of(eg[c], 1'b0));
            end
        end
        reset = 1'b1;
        req   = 4'b0000;
        step();
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_hold_limit();
        logic [3:0] g;
        logic [7:0] ob;
        do_reset();
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            g = 4'b0001 << (i % 4);
            for (int c = 0; c < 8; c++) begin
                ob = {gnt, gnt_id, busy, timeout};
                checks++;
                if (ob !== exp_of(g, 1'b0)) begin
                    errors++;
                    $display("FAIL rot_grant i%0d c%0d: got %b want %b",
                             i, c, ob, exp_of(g, 1'b0));
                end
                step();
            end
            ob = {gnt, gnt_id, busy, timeout};
            checks++;
            if (ob !== exp_of(4'b0000, 1'b1)) begin
                errors++;
                $display("FAIL rot_timeout i%0d: got %b want %b",
                         i, ob, exp_of(4'b0000, 1'b1));
            end
            step();
            ob = {gnt, gnt_id, busy, timeout};
            checks++;
            if (ob !== exp_of(4'b0000, 1'b0)) begin
                errors++;
                $display("FAIL rot_idle i%0d: got %b want %b",
                         i, ob, exp_of(4'b0000, 1'b0));
            end
            step();
        end
        req = 4'b0000;
        step();
        step();
        // Release in the limit cycle must not pulse timeout.
        do_reset();
        req = 4'b0001;
        step();
        for (int c = 0; c < 8; c++) begin
            ob = {gnt, gnt_id, busy, timeout};
            checks++;
            if (ob !== exp_of(4'b0001, 1'b0)) begin
                errors++;
                $display("FAIL limit_hold c%0d: got %b want %b",
                         c, ob, exp_of(4'b0001, 1'b0));
            end
            if (c == 7) req = 4'b0000;
            step();
        end
        ob = {gnt, gnt_id, busy, timeout};
        checks++;
        if (ob !== exp_of(4'b0000, 1'b0)) begin
            errors++;
            $display("FAIL release_vs_timeout: got %b want %b",
                     ob, exp_of(4'b0000, 1'b0));
        end
        step();
    endtask
`else
    task automatic test_hold_limit();
        logic [7:0] ob;
        do_reset();
        req = 4'b0011;
        step();
        for (int c = 0; c < 50; c++) begin
            ob = {gnt, gnt_id, busy, timeout};
            checks++;
            if (ob !== exp_of(4'b0001, 1'b0)) begin
                errors++;
                $display("FAIL no_limit c%0d: got %b want %b",
                         c, ob, exp_of(4'b0001, 1'b0));
            end
            step();
        end
        req = 4'b0000;
        step();
        ob = {gnt, gnt_id, busy, timeout};
        checks++;
        if (ob !== exp_of(4'b0000, 1'b0)) begin
            errors++;
            $display("FAIL no_limit_release: got %b want %b",
                     ob, exp_of(4'b0000, 1'b0));
        end
        step();
    endtask
`endif

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        test_reset();
        test_voluntary_release();
        test_pointer_fairness();
        test_ignore_others();
        test_reset_mid_grant();
        test_hold_limit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
